// File: rtl/histogram_readout_if.sv
// Byte-stream link from the histogram reader to the host transmitter.
// valid/ready handshake: a byte moves on any cycle where both are high.
interface histogram_readout_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/histogram_readout.sv
// Freezes the coincidence histogram, streams header + all bin counts + XOR checksum
// over the byte link, and optionally zeroes each bin once it has been read.
module histogram_readout #(
    parameter int          NBINS    = 128,
    parameter int          COUNT_W  = 16,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dump_req,
    input  logic               clear_en,
    output logic               mem_rd_en,
    output logic [6:0]         mem_rd_addr,
    input  logic [COUNT_W-1:0] mem_rd_data,
    output logic               mem_wr_en,
    output logic [6:0]         mem_wr_addr,
    output logic [COUNT_W-1:0] mem_wr_data,
    output logic               hist_freeze,
    histogram_readout_if.master tx,
    output logic               busy,
    output logic               done
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_HDR  = 4'd1;
    localparam logic [3:0] S_RD   = 4'd2;
    localparam logic [3:0] S_WAIT = 4'd3;
    localparam logic [3:0] S_HI   = 4'd4;
    localparam logic [3:0] S_LO   = 4'd5;
    localparam logic [3:0] S_CLR  = 4'd6;
    localparam logic [3:0] S_NEXT = 4'd7;
    localparam logic [3:0] S_TRL  = 4'd8;
    localparam logic [3:0] S_DONE = 4'd9;

    localparam logic [6:0] LAST_ADDR = 7'(NBINS - 1);

    logic [3:0]         state_q, state_d;
    logic [6:0]         addr_q, addr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [7:0]         csum_q, csum_d;
    logic               clr_q, clr_d;
    logic               hs;

    assign hs = tx.tx_valid && tx.tx_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        csum_d  = csum_q;
        clr_d   = clr_q;
        case (state_q)
            S_IDLE: if (dump_req) begin
                clr_d   = clear_en;
                csum_d  = '0;
                addr_d  = '0;
                state_d = S_HDR;
            end
            S_HDR:  if (hs) state_d = S_RD;
            S_RD:   state_d = S_WAIT;
            S_WAIT: begin
                count_d = mem_rd_data;
                state_d = S_HI;
            end
            S_HI: if (hs) begin
                csum_d  = csum_q ^ count_q[COUNT_W-1 -: 8];
                state_d = S_LO;
            end
            S_LO: if (hs) begin
                csum_d  = csum_q ^ count_q[7:0];
                state_d = clr_q ? S_CLR : S_NEXT;
            end
            S_CLR:  state_d = S_NEXT;
            S_NEXT: if (addr_q == LAST_ADDR) begin
                state_d = S_TRL;
            end else begin
                addr_d  = addr_q + 7'd1;
                state_d = S_RD;
            end
            S_TRL:  if (hs) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            csum_q  <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            csum_q  <= csum_d;
            clr_q   <= clr_d;
        end
    end

    // Outputs decode the state register only, so an async reset zeroes them at once.
    always_comb begin
        tx.tx_valid = 1'b0;
        tx.tx_data  = '0;
        case (state_q)
            S_HDR: begin tx.tx_valid = 1'b1; tx.tx_data = HDR_BYTE;               end
            S_HI:  begin tx.tx_valid = 1'b1; tx.tx_data = count_q[COUNT_W-1 -: 8]; end
            S_LO:  begin tx.tx_valid = 1'b1; tx.tx_data = count_q[7:0];           end
            S_TRL: begin tx.tx_valid = 1'b1; tx.tx_data = csum_q;                 end
            default: ;
        endcase
    end

    assign mem_rd_en   = (state_q == S_RD);
    assign mem_rd_addr = mem_rd_en ? addr_q : '0;
    assign mem_wr_en   = (state_q == S_CLR);
    assign mem_wr_addr = mem_wr_en ? addr_q : '0;
    assign mem_wr_data = '0;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign hist_freeze = busy;
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_histogram_readout.sv
// Bench for histogram_readout: behavioural RAM + writer, frame model built from the
// frame format, table of frame scenarios plus a mid-frame reset sequence.
module tb_histogram_readout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, dump_req, clear_en;
    logic        mem_rd_en, mem_wr_en, hist_freeze, busy, done;
    logic [6:0]  mem_rd_addr, mem_wr_addr;
    logic [15:0] mem_rd_data, mem_wr_data;

    histogram_readout_if tx_if ();

    histogram_readout #(.NBINS(128), .COUNT_W(16), .HDR_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .dump_req(dump_req), .clear_en(clear_en),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .hist_freeze(hist_freeze), .tx(tx_if), .busy(busy), .done(done)
    );

    // Histogram RAM with the bin-address writer; writer increments drop while frozen.
    logic [15:0] ram  [128];
    logic [15:0] img  [128];
    logic [15:0] snap [128];
    logic        load_en, inc_en;
    logic [6:0]  inc_addr;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
        if (load_en) begin
            for (int k = 0; k < 128; k++) ram[k] <= img[k];
        end else if (mem_wr_en) begin
            ram[mem_wr_addr] <= mem_wr_data;
        end else if (inc_en && !hist_freeze) begin
            ram[inc_addr] <= ram[inc_addr] + 16'd1;
        end
    end

    int total = 0, passed = 0;
    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // kind: 0 ramp k*257, 1 only bin64=0x1234, 2 keep current RAM, 3 random
    task automatic preload(input int kind);
        if (kind == 2) return;
        for (int k = 0; k < 128; k++) begin
            case (kind)
                0:       img[k] = 16'(k * 257);
                1:       img[k] = (k == 64) ? 16'h1234 : 16'h0000;
                default: img[k] = 16'($urandom);
            endcase
        end
        @(negedge clk); load_en = 1'b1;
        @(negedge clk); load_en = 1'b0;
    endtask

    logic [7:0] expq [$];
    logic [7:0] rxq  [$];

    function automatic void build_expected();
        logic [7:0] cs = 8'h00;
        expq.delete();
        expq.push_back(8'hA5);
        for (int k = 0; k < 128; k++) begin
            expq.push_back(snap[k] / 256);
            expq.push_back(snap[k] % 256);
            cs = cs ^ 8'(snap[k] / 256) ^ 8'(snap[k] % 256);
        end
        expq.push_back(cs);
    endfunction

    int done_cnt, stab_err, overlap_err, freeze_err, done_cyc, after_err;
    bit first_valid, done_seen;

    task automatic run_frame(input bit clr, input int pct, input bit mid, input bit incs,
                             input int abort_bin, output bit aborted);
        int   cyc = 0;
        bit   prev_stall = 0, mid_sent = 0;
        logic [7:0] prev_data = '0;
        rxq.delete();
        done_cnt = 0; stab_err = 0; overlap_err = 0; freeze_err = 0;
        done_cyc = 0; after_err = 0; first_valid = 0; done_seen = 0; aborted = 0;
        @(negedge clk);
        snap = ram;
        build_expected();
        clear_en = clr; dump_req = 1'b1;
        while (!done_seen && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            dump_req = 1'b0;
            if (mid && !mid_sent && rxq.size() >= 21) begin
                dump_req = 1'b1; clear_en = ~clr; mid_sent = 1;
            end
            tx_if.tx_ready = ($urandom_range(99) < 32'(pct));
            inc_en   = incs && busy && ($urandom_range(1) == 1);
            inc_addr = 7'($urandom);
            #1;
            if (cyc == 1) first_valid = tx_if.tx_valid && (tx_if.tx_data == 8'hA5);
            if (prev_stall && (!tx_if.tx_valid || tx_if.tx_data != prev_data)) stab_err++;
            prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
            prev_data  = tx_if.tx_data;
            if (tx_if.tx_valid && tx_if.tx_ready) rxq.push_back(tx_if.tx_data);
            if (mem_rd_en && mem_wr_en) overlap_err++;
            if (!done && (!hist_freeze || !busy)) freeze_err++;
            if (done) begin done_seen = 1; done_cnt++; done_cyc = cyc; end
            if (abort_bin >= 0 && mem_wr_en && mem_wr_addr == 7'(abort_bin)) begin
                aborted = 1; break;
            end
        end
        inc_en = 1'b0; dump_req = 1'b0;
        if (aborted) return;
        repeat (5) begin
            @(negedge clk); #1;
            if (done) done_cnt++;
            if (busy || hist_freeze || tx_if.tx_valid) after_err++;
        end
    endtask

    typedef struct {
        int kind; bit clr; int pct; bit mid; bit inc; int csum;
    } vec_t;
    vec_t vecs [7];

    initial begin
        bit ab;
        int mism, first_bad, err;

        vecs[0] = '{kind: 0, clr: 0, pct: 100, mid: 0, inc: 0, csum: 8'h00};
        vecs[1] = '{kind: 1, clr: 1, pct: 100, mid: 0, inc: 0, csum: 8'h26};
        vecs[2] = '{kind: 2, clr: 0, pct: 100, mid: 0, inc: 0, csum: 8'h00};
        vecs[3] = '{kind: 0, clr: 0, pct: 30,  mid: 0, inc: 0, csum: 8'h00};
        vecs[4] = '{kind: 3, clr: 0, pct: 30,  mid: 0, inc: 1, csum: -1};
        vecs[5] = '{kind: 0, clr: 0, pct: 100, mid: 1, inc: 0, csum: 8'h00};
        vecs[6] = '{kind: 3, clr: 1, pct: 50,  mid: 0, inc: 0, csum: -1};

        rst_n = 1'b0; dump_req = 1'b0; clear_en = 1'b0; tx_if.tx_ready = 1'b0;
        load_en = 1'b0; inc_en = 1'b0; inc_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
              hist_freeze, tx_if.tx_valid, tx_if.tx_data, busy, done}, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            preload(vecs[v].kind);
            run_frame(vecs[v].clr, vecs[v].pct, vecs[v].mid, vecs[v].inc, -1, ab);
            check($sformatf("v%0d_done_seen", v), done_seen, 1);
            check($sformatf("v%0d_byte_count", v), rxq.size(), 258);
            mism = 0; first_bad = -1;
            for (int i = 0; i < 258; i++) begin
                if (i >= rxq.size() || rxq[i] !== expq[i]) begin
                    mism++;
                    if (first_bad < 0) first_bad = i;
                end
            end
            check($sformatf("v%0d_seq_mismatches(first@%0d)", v, first_bad), mism, 0);
            check($sformatf("v%0d_checksum", v), (rxq.size() == 258) ? rxq[257] : -1,
                  (vecs[v].csum < 0) ? expq[257] : vecs[v].csum);
            if (vecs[v].kind == 1)
                check("v1_bin64_bytes", (rxq.size() == 258) ? {rxq[129], rxq[130]} : -1, 16'h1234);
            check($sformatf("v%0d_done_pulses", v), done_cnt, 1);
            check($sformatf("v%0d_idle_after", v), after_err, 0);
            check($sformatf("v%0d_tx_stable", v), stab_err, 0);
            check($sformatf("v%0d_rd_wr_overlap", v), overlap_err, 0);
            check($sformatf("v%0d_freeze", v), freeze_err, 0);
            check($sformatf("v%0d_first_valid", v), first_valid, 1);
            if (vecs[v].pct == 100)
                check($sformatf("v%0d_frame_cycles", v), done_cyc, vecs[v].clr ? 771 : 643);
            err = 0;
            for (int k = 0; k < 128; k++)
                if (ram[k] !== (vecs[v].clr ? 16'h0000 : snap[k])) err++;
            check($sformatf("v%0d_ram_after", v), err, 0);
        end

        // Mid-frame reset right after bin 50 has been cleared.
        preload(0);
        run_frame(1'b1, 100, 1'b0, 1'b0, 50, ab);
        check("abort_reached_bin50", ab, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs_zero", {mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
              hist_freeze, tx_if.tx_valid, tx_if.tx_data, busy, done}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        err = 0;
        for (int k = 0; k < 128; k++)
            if (ram[k] !== ((k <= 50) ? 16'h0000 : 16'(k * 257))) err++;
        check("abort_ram_state", err, 0);
        check("abort_idle_busy", busy, 0);
        run_frame(1'b0, 100, 1'b0, 1'b0, -1, ab);
        check("restart_header", (rxq.size() > 0) ? rxq[0] : -1, 8'hA5);
        check("restart_bin0", (rxq.size() > 2) ? {rxq[1], rxq[2]} : -1, 16'h0000);
        check("restart_bin51", (rxq.size() > 104) ? {rxq[103], rxq[104]} : -1, 16'(51 * 257));
        check("restart_byte_count", rxq.size(), 258);
        mism = 0;
        for (int i = 0; i < 258; i++)
            if (i >= rxq.size() || rxq[i] !== expq[i]) mism++;
        check("restart_seq_mismatches", mism, 0);
        check("restart_done_pulses", done_cnt, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
